traffic_phase_sequencer: RTL and testbench

- Timed phase sequencer for a highway / country-road intersection.
- Drives both 3-bit signal heads through green, yellow and all-red phases.
- Highway rests on green. Latched car-sensor and pedestrian requests win a bounded country green.
- An emergency input holds or returns right-of-way to the highway.
- Sits between the road sensors and the lamp drivers, replacing the fixed-delay controller with parameterised per-phase timers.

---
 rtl/traffic_pkg.sv | 34 +++
 rtl/phase_timer.sv | 32 +++
 rtl/traffic_phase_checker.sv | 19 +
 rtl/traffic_phase_sequencer.sv | 138 +++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase enumeration and phase-to-lamp decode for the
// highway / country-road intersection sequencer.
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
  } phase_t;

  // Returns {highway, country} lamp patterns for a phase; unknown encodings
  // fall back to all-red so a corrupted state can never show a conflict.
  function automatic logic [5:0] lamp_of(input phase_t p);
    logic [5:0] lamps;
    case (p)
      HG:      lamps = {GREEN,  RED};
      HY:      lamps = {YELLOW, RED};
      AR1:     lamps = {RED,    RED};
      CG:      lamps = {RED,    GREEN};
      CY:      lamps = {RED,    YELLOW};
      AR2:     lamps = {RED,    RED};
      default: lamps = {RED,    RED};
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase up-counter: cleared on phase change, optionally parks at the
// terminal value, and reports equality / reached comparisons against it.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          sat_en,
  input  logic [TW-1:0] term,
  output logic [TW-1:0] count,
  output logic          at_term,
  output logic          past_term
);

  // Count register: zero on reset or phase change, hold at term when parked.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (sat_en && past_term) begin
      count <= count;
    end else begin
      count <= count + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign at_term   = (count == term);
  assign past_term = (count >= term);

endmodule

// File: rtl/traffic_phase_checker.sv
// Safety properties on the lamp outputs: the two roads never show a
// non-red aspect at the same time, and walk only runs against highway red.
module traffic_phase_checker
  import traffic_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic [2:0] highway,
  input logic [2:0] country,
  input logic       walk
);

  conflict_free: assert property (@(posedge clk) disable iff (rst)
    (highway == RED) || (country == RED));

  walk_safe: assert property (@(posedge clk) disable iff (rst)
    walk |-> (highway == RED));

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Timed phase sequencer: highway rests green, latched car / pedestrian
// requests earn a bounded country green, emergency keeps or returns
// right-of-way to the highway. Lamps decode from the registered phase.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int TW      = 8,
  parameter int HG_MIN  = 8,
  parameter int Y_TIME  = 3,
  parameter int AR_TIME = 2,
  parameter int CG_MIN  = 4,
  parameter int CG_MAX  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_sensor,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] highway,
  output logic [2:0] country,
  output logic       walk,
  output logic       ped_ack
);

  // Terminal timer values: a phase of N cycles is done when the timer reads N-1.
  localparam logic [TW-1:0] HG_TERM    = TW'(HG_MIN - 1);
  localparam logic [TW-1:0] Y_TERM     = TW'(Y_TIME - 1);
  localparam logic [TW-1:0] AR_TERM    = TW'(AR_TIME - 1);
  localparam logic [TW-1:0] CGMIN_TERM = TW'(CG_MIN - 1);
  localparam logic [TW-1:0] CGMAX_TERM = TW'(CG_MAX - 1);
  localparam logic [TW-1:0] WALK_END   = TW'(CG_MIN);

  phase_t        state_r;
  phase_t        next_s;
  logic          car_pend_r;
  logic          ped_pend_r;
  logic          ped_served_r;
  logic [TW-1:0] term_s;
  logic          sat_s;
  logic [TW-1:0] count_s;
  logic          at_s;
  logic          past_s;
  logic          change_s;
  logic          enter_cg_s;
  logic [5:0]    lamps_s;

  phase_timer #(.TW(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (change_s),
    .sat_en    (sat_s),
    .term      (term_s),
    .count     (count_s),
    .at_term   (at_s),
    .past_term (past_s)
  );

  // Next-phase selection and timer terminal / park control for the current phase.
  always_comb begin
    next_s = state_r;
    term_s = HG_TERM;
    sat_s  = 1'b0;
    case (state_r)
      HG: begin
        term_s = HG_TERM;
        sat_s  = 1'b1;
        if (past_s && (car_pend_r || ped_pend_r) && !emerg) next_s = HY;
        else                                                 next_s = HG;
      end
      HY: begin
        term_s = Y_TERM;
        if (at_s) next_s = AR1;
        else      next_s = HY;
      end
      AR1: begin
        term_s = AR_TERM;
        if (at_s) next_s = CG;
        else      next_s = AR1;
      end
      CG: begin
        term_s = CGMIN_TERM;
        if (emerg || (past_s && !car_sensor) || (count_s == CGMAX_TERM)) next_s = CY;
        else                                                             next_s = CG;
      end
      CY: begin
        term_s = Y_TERM;
        if (at_s) next_s = AR2;
        else      next_s = CY;
      end
      AR2: begin
        term_s = AR_TERM;
        if (at_s) next_s = HG;
        else      next_s = AR2;
      end
      default: begin
        term_s = HG_TERM;
        next_s = HG;
      end
    endcase
  end

  assign change_s   = (next_s != state_r);
  assign enter_cg_s = (state_r == AR1) && (next_s == CG);

  // Phase register, request latches (a new request beats the clear) and the
  // pedestrian-served flag captured as the country green starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= HG;
      car_pend_r   <= 1'b0;
      ped_pend_r   <= 1'b0;
      ped_served_r <= 1'b0;
    end else begin
      state_r    <= next_s;
      car_pend_r <= car_sensor | (car_pend_r & ~enter_cg_s);
      ped_pend_r <= ped_req    | (ped_pend_r & ~enter_cg_s);
      if (enter_cg_s) ped_served_r <= ped_pend_r;
      else            ped_served_r <= ped_served_r;
    end
  end

  assign lamps_s = lamp_of(state_r);
  assign highway = lamps_s[5:3];
  assign country = lamps_s[2:0];
  // Walk runs for the first CG_MIN cycles of a served country green and
  // drops as soon as the phase leaves CG (including an emergency exit).
  assign walk    = (state_r == CG) && ped_served_r && (count_s < WALK_END);
  assign ped_ack = (state_r == CG) && ped_served_r && (count_s == {TW{1'b0}});

  traffic_phase_checker u_chk (
    .clk     (clk),
    .rst     (rst),
    .highway (highway),
    .country (country),
    .walk    (walk)
  );

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench: directed timelines plus randomized traffic compared
// against a cycle-level phase-index / elapsed-time reference model.
module tb_traffic_phase_sequencer;

  localparam int HG_MIN  = 8;
  localparam int Y_TIME  = 3;
  localparam int AR_TIME = 2;
  localparam int CG_MIN  = 4;
  localparam int CG_MAX  = 10;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       car_sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic       emerg = 1'b0;
  logic [2:0] highway;
  logic [2:0] country;
  logic       walk;
  logic       ped_ack;
  logic [7:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: phase index 0..5 in road order, cycles spent in phase.
  int m_phase = 0;
  int m_age = 0;
  bit m_car = 1'b0;
  bit m_ped = 1'b0;
  bit m_served = 1'b0;
  logic [2:0] hw_tab [6] = '{G, Y, R, R, R, R};
  logic [2:0] cr_tab [6] = '{R, R, R, G, Y, R};

  traffic_phase_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .car_sensor (car_sensor),
    .ped_req    (ped_req),
    .emerg      (emerg),
    .highway    (highway),
    .country    (country),
    .walk       (walk),
    .ped_ack    (ped_ack)
  );

  assign dut_vec = {highway, country, walk, ped_ack};

  always #5 clk = ~clk;

  function automatic bit m_leave(input bit car_in, input bit em);
    case (m_phase)
      0:       return (m_age >= HG_MIN - 1) && (m_car || m_ped) && !em;
      1, 4:    return m_age == Y_TIME - 1;
      2, 5:    return m_age == AR_TIME - 1;
      3:       return em || ((m_age >= CG_MIN - 1) && !car_in) || (m_age == CG_MAX - 1);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] exp_vec();
    logic w;
    logic a;
    w = (m_phase == 3) && m_served && (m_age < CG_MIN);
    a = (m_phase == 3) && m_served && (m_age == 0);
    return {hw_tab[m_phase], cr_tab[m_phase], w, a};
  endfunction

  // Advance one clock: model consumes the inputs present at the edge.
  task automatic step();
    bit lv;
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_age = 0; m_car = 1'b0; m_ped = 1'b0; m_served = 1'b0;
    end else begin
      lv = m_leave(car_sensor, emerg);
      if (m_phase == 2 && lv) begin
        m_served = m_ped;
        m_car = car_sensor;
        m_ped = ped_req;
      end else begin
        m_car = m_car | car_sensor;
        m_ped = m_ped | ped_req;
      end
      if (lv) begin
        m_phase = (m_phase + 1) % 6;
        m_age = 0;
      end else begin
        m_age++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; car_sensor = 1'b0; ped_req = 1'b0; emerg = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; car_sensor = 1'b1; ped_req = 1'b1; emerg = 1'b0;
    step();
    step();
    checks++;
    if (dut_vec !== 8'b001_100_0_0) begin
      errors++; $display("FAIL reset_state: got %b expected %b", dut_vec, 8'b001_100_0_0);
    end
    rst = 1'b0; car_sensor = 1'b0; ped_req = 1'b0;
    for (int c = 0; c < 60; c++) begin
      checks++;
      if (dut_vec !== 8'b001_100_0_0) begin
        errors++; $display("FAIL idle cycle %0d: got %b expected %b", c, dut_vec, 8'b001_100_0_0);
      end
      step();
    end
  endtask

  task automatic test_car_held();
    logic [2:0] ehw;
    logic [2:0] ecr;
    do_reset();
    car_sensor = 1'b1;
    for (int c = 0; c < 36; c++) begin
      ehw = (c < 8) ? G : (c < 11) ? Y : (c < 28) ? R : G;
      ecr = (c < 13) ? R : (c < 23) ? G : (c < 26) ? Y : R;
      checks++;
      if ({highway, country} !== {ehw, ecr}) begin
        errors++; $display("FAIL car_held_timeline cycle %0d: got %b expected %b", c, {highway, country}, {ehw, ecr});
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL car_held_model cycle %0d: got %b expected %b", c, dut_vec, exp_vec());
      end
      step();
    end
    car_sensor = 1'b0;
  endtask

  task automatic test_car_pulse();
    int         sc [6] = '{8, 13, 16, 17, 21, 22};
    logic [5:0] sp [6] = '{{Y, R}, {R, G}, {R, G}, {R, Y}, {R, R}, {G, R}};
    do_reset();
    for (int c = 0; c < 30; c++) begin
      car_sensor = (c == 2);
      for (int k = 0; k < 6; k++) begin
        if (c == sc[k]) begin
          checks++;
          if ({highway, country} !== sp[k]) begin
            errors++; $display("FAIL car_pulse cycle %0d: got %b expected %b", c, {highway, country}, sp[k]);
          end
        end
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL car_pulse_model cycle %0d: got %b expected %b", c, dut_vec, exp_vec());
      end
      step();
    end
    car_sensor = 1'b0;
  endtask

  task automatic test_ped();
    do_reset();
    for (int c = 0; c < 26; c++) begin
      ped_req = (c == 1);
      checks++;
      if ({walk, ped_ack} !== {(c >= 13 && c <= 16), (c == 13)}) begin
        errors++; $display("FAIL ped_walk_ack cycle %0d: got %b expected %b", c, {walk, ped_ack}, {(c >= 13 && c <= 16), (c == 13)});
      end
      if (c == 17) begin
        checks++;
        if (country !== Y) begin
          errors++; $display("FAIL ped_cy cycle %0d: got %b expected %b", c, country, Y);
        end
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ped_model cycle %0d: got %b expected %b", c, dut_vec, exp_vec());
      end
      step();
    end
    ped_req = 1'b0;
  endtask

  task automatic test_emerg();
    int         sc [8] = '{16, 17, 19, 20, 22, 45, 46, 47};
    logic [5:0] sp [8] = '{{R, G}, {R, Y}, {R, Y}, {R, R}, {G, R}, {G, R}, {G, R}, {Y, R}};
    do_reset();
    car_sensor = 1'b1;
    for (int c = 0; c < 52; c++) begin
      emerg = (c >= 16 && c <= 45);
      for (int k = 0; k < 8; k++) begin
        if (c == sc[k]) begin
          checks++;
          if ({highway, country} !== sp[k]) begin
            errors++; $display("FAIL emerg cycle %0d: got %b expected %b", c, {highway, country}, sp[k]);
          end
        end
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL emerg_model cycle %0d: got %b expected %b", c, dut_vec, exp_vec());
      end
      step();
    end
    car_sensor = 1'b0; emerg = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 70; c++) begin
      rst = (c == 24);
      car_sensor = (c < 24);
      if (c == 24) begin
        checks++;
        if ({highway, country} !== {R, Y}) begin
          errors++; $display("FAIL reset_mid_cy cycle %0d: got %b expected %b", c, {highway, country}, {R, Y});
        end
      end
      if (c >= 25) begin
        checks++;
        if ({highway, country, walk} !== {G, R, 1'b0}) begin
          errors++; $display("FAIL reset_mid_hg cycle %0d: got %b expected %b", c, {highway, country, walk}, {G, R, 1'b0});
        end
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_mid_model cycle %0d: got %b expected %b", c, dut_vec, exp_vec());
      end
      step();
    end
    rst = 1'b0; car_sensor = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(299, 0) == 0);
      car_sensor = ($urandom_range(3, 0) == 0);
      ped_req    = ($urandom_range(15, 0) == 0);
      if ($urandom_range(19, 0) == 0) emerg = ~emerg;
      checks++;
      if (!((highway == R) || (country == R))) begin
        errors++; $display("FAIL random_conflict cycle %0d: got %b/%b expected one head red", c, highway, country);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_model cycle %0d: got %b expected %b", c, dut_vec, exp_vec());
      end
      step();
    end
    rst = 1'b0; car_sensor = 1'b0; ped_req = 1'b0; emerg = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_car_held();
    test_car_pulse();
    test_ped();
    test_emerg();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
